stall_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage pipelined CPU; drives the `en` inputs of the PC and pipeline enable-registers and the bubble/flush controls.
- Detects load-use hazards, holds the pipeline for multi-cycle multiplies, and handles taken-branch flushes.
- Sits between the ID/EX decode signals and the enable-register instances (PC, IF/ID, ID/EX) it controls.

---
 rtl/stall_ctrl.sv | 122 ++++++++++++
 tb/tb_stall_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, multi-cycle
// multiply holds and taken-branch flushes, plus a saturating stall-cycle counter.
module stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memRead,
  input  logic             mul_start,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             ifid_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {RUN, MUL} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          mul_done, mul_done_next;
  logic          lu;

  // XZR is never a real producer, so it can never cause a load-use stall.
  assign lu = ex_memRead && (ex_rd != REG_W'(ZERO_REG)) &&
              ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      cnt      <= '0;
      mul_done <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      mul_done <= mul_done_next;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    idex_bubble   = 1'b0;
    exmem_bubble  = 1'b0;
    ifid_flush    = 1'b0;
    mul_busy      = 1'b0;
    state_next    = state;
    cnt_next      = cnt;
    mul_done_next = 1'b0;

    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b1;
      state_next  = RUN;
      cnt_next    = '0;
    end else begin
      case (state)
        RUN: begin
          // mul_start is still high for the just-finished multiply on the cycle after MUL.
          if (mul_start && !mul_done) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            if (MUL_LAT > 2) begin
              state_next = MUL;
              cnt_next   = CW'(MUL_LAT - 2);
            end else begin
              mul_done_next = 1'b1;
            end
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MUL: begin
          mul_busy     = 1'b1;
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          cnt_next     = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_next    = RUN;
            mul_done_next = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: vector table plus reset-mid-multiply
// and counter-saturation sequences (second instance built with a 4-bit counter).
module tb_stall_ctrl;

  typedef struct {
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic [4:0] rd;
    logic       mrd;
    logic       mst;
    logic       br;
    logic [6:0] exp_out;
    int         exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic id_uses_rn, id_uses_rm, ex_memRead, mul_start, branch_taken;
  logic pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush, mul_busy;
  logic [31:0] stall_cycles;
  logic s_pc_en, s_ifid_en, s_idex_en, s_idex_bubble, s_exmem_bubble, s_ifid_flush, s_mul_busy;
  logic [3:0] s_stall_cycles;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[19];

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .mul_start(mul_start), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .ifid_flush(ifid_flush), .mul_busy(mul_busy),
    .stall_cycles(stall_cycles)
  );

  stall_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .mul_start(mul_start), .branch_taken(branch_taken),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .idex_bubble(s_idex_bubble),
    .exmem_bubble(s_exmem_bubble), .ifid_flush(s_ifid_flush), .mul_busy(s_mul_busy),
    .stall_cycles(s_stall_cycles)
  );

  // Expected output bit order: {pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush, mul_busy}
  function automatic vec_t mkv(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                               input logic urm, input logic [4:0] rd, input logic mrd,
                               input logic mst, input logic br, input logic [6:0] e, input int st);
    vec_t v;
    v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm; v.rd = rd;
    v.mrd = mrd; v.mst = mst; v.br = br; v.exp_out = e; v.exp_stall = st;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    id_rn = v.rn; id_rm = v.rm; id_uses_rn = v.urn; id_uses_rm = v.urm;
    ex_rd = v.rd; ex_memRead = v.mrd; mul_start = v.mst; branch_taken = v.br;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] e, input int st);
    logic [6:0] act;
    act = {pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush, mul_busy};
    vectors++;
    if (act !== e || stall_cycles !== 32'(st)) begin
      miscompares++;
      $display("[TB] FAIL %s: outputs=%b stall_cycles=%0d, expected outputs=%b stall_cycles=%0d",
               name, act, stall_cycles, e, st);
    end
  endtask

  task automatic checkSat(input string name, input int st);
    vectors++;
    if (s_stall_cycles !== 4'(st)) begin
      miscompares++;
      $display("[TB] FAIL %s: sat stall_cycles=%0d, expected %0d", name, s_stall_cycles, st);
    end
  endtask

  initial begin
    vec_t idle, mulv, luv;
    idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b1110000, 0);
    mulv = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7'b0000100, 0);
    luv  = mkv(3, 0, 1, 0, 3, 1, 0, 0, 7'b0011000, 0);

    tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b1110000, 0);
    tbl[1]  = mkv(1, 2, 1, 1, 4, 0, 0, 0, 7'b1110000, 0);
    tbl[2]  = mkv(3, 0, 1, 0, 3, 1, 0, 0, 7'b0011000, 0);
    tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b1110000, 1);
    tbl[4]  = mkv(31, 0, 1, 0, 31, 1, 0, 0, 7'b1110000, 1);
    tbl[5]  = mkv(7, 7, 0, 1, 7, 1, 0, 0, 7'b0011000, 1);
    tbl[6]  = mkv(5, 0, 0, 0, 5, 1, 0, 0, 7'b1110000, 2);
    tbl[7]  = mkv(5, 5, 1, 1, 5, 0, 0, 0, 7'b1110000, 2);
    tbl[8]  = mkv(3, 0, 1, 0, 3, 1, 0, 1, 7'b1111010, 2);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7'b0000100, 2);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7'b0000101, 3);
    tbl[11] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7'b0000101, 4);
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 7'b1110000, 5);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b1110000, 5);
    tbl[14] = mkv(3, 0, 1, 0, 3, 1, 1, 1, 7'b0000100, 5);
    tbl[15] = mkv(3, 0, 1, 0, 3, 1, 1, 1, 7'b0000101, 6);
    tbl[16] = mkv(3, 0, 1, 0, 3, 1, 0, 0, 7'b0000101, 7);
    tbl[17] = mkv(3, 0, 1, 0, 3, 1, 0, 0, 7'b0011000, 8);
    tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b1110000, 9);

    reset = 1'b0;
    id_rn = '0; id_rm = '0; id_uses_rn = 0; id_uses_rm = 0;
    ex_rd = '0; ex_memRead = 0; mul_start = 0; branch_taken = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_hold", 7'b0001000, 0);
    end
    checkSat("reset_sat", 0);

    @(posedge clk);
    reset = 1'b1;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_stall);
    end

    // Reset dropped on the first MUL cycle of a multiply.
    applyStimulus(mulv);
    @(negedge clk);
    checkOutput("mid_mul_start", 7'b0000100, 9);
    applyStimulus(mulv);
    @(negedge clk);
    checkOutput("mid_mul_busy", 7'b0000101, 10);
    reset = 1'b0;
    #1;
    checkOutput("mid_mul_reset", 7'b0001000, 0);
    checkSat("mid_mul_reset_sat", 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("fresh_mul0", 7'b0000100, 0);
    applyStimulus(mulv);
    @(negedge clk);
    checkOutput("fresh_mul1", 7'b0000101, 1);
    applyStimulus(mulv);
    @(negedge clk);
    checkOutput("fresh_mul2", 7'b0000101, 2);
    applyStimulus(mulv);
    @(negedge clk);
    checkOutput("fresh_mul_done", 7'b1110000, 3);
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("fresh_mul_idle", 7'b1110000, 3);

    // 20 consecutive load-use stalls: 4-bit counter must stick at 15.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(luv);
      @(negedge clk);
      checkOutput($sformatf("lu_run%0d", i), 7'b0011000, 3 + i);
      checkSat($sformatf("lu_sat%0d", i), (3 + i > 15) ? 15 : 3 + i);
    end
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("sat_after", 7'b1110000, 23);
    checkSat("sat_hold", 15);
    applyStimulus(idle);
    @(negedge clk);
    checkSat("sat_hold2", 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
